gpio_drive_arbiter: RTL and testbench

Shares a single GPIO output pin bus between several internal requesters. Each requester posts a pin value and a hold duration over a valid/ready handshake. The arbiter grants one requester at a time, drives its value onto the pins for the requested number of cycles, then re-arbitrates. It sits directly in front of the GPIO pin bus that the GPIO agent observes and drives in simulation.

---
 rtl/gpio_arb_pkg.sv | 16 +
 rtl/gpio_rr_picker.sv | 35 +++
 rtl/gpio_drive_arbiter.sv | 122 ++++++++++++
 tb/tb_gpio_drive_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_arb_pkg.sv
// Shared types and default sizes for the GPIO drive arbiter and its picker.
package gpio_arb_pkg;

  localparam int GPIO_ARB_NUM_REQ    = 4;
  // Matches the width of gpio_uvc_data_t used by the GPIO agent.
  localparam int GPIO_ARB_DATA_WIDTH = 32;
  localparam int GPIO_ARB_HOLD_W     = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } arb_state_t;

  typedef logic [GPIO_ARB_HOLD_W-1:0] hold_cnt_t;

endpackage

// File: rtl/gpio_rr_picker.sv
// Rotate-and-priority select: first valid requester at or after ptr_i, wrapping
// modulo NUM_REQ. Returns the winner one-hot and as an index.
module gpio_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] sel_oh_o,
  output logic [IDX_W-1:0]   sel_idx_o,
  output logic               any_o
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    int               raw;
    sel_oh_o  = '0;
    sel_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    raw       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr_i is always below NUM_REQ, so one subtraction is enough to wrap.
      raw = int'(ptr_i) + k;
      if (raw >= NUM_REQ) raw = raw - NUM_REQ;
      idx = IDX_W'(raw);
      if (!any_o && valid_i[idx]) begin
        any_o         = 1'b1;
        sel_idx_o     = idx;
        sel_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_drive_arbiter.sv
// Shares the GPIO pin bus between NUM_REQ requesters, holding each grant for hold+1 cycles.
// Define GPIO_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module gpio_drive_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int NUM_REQ    = GPIO_ARB_NUM_REQ,
  parameter int DATA_WIDTH = GPIO_ARB_DATA_WIDTH,
  parameter int HOLD_W     = GPIO_ARB_HOLD_W
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ*HOLD_W-1:0]    req_hold_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [DATA_WIDTH-1:0]        gpio_pin_o,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic                         busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t              state_q, state_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [DATA_WIDTH-1:0]   pin_q, pin_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        sel_idx;
  logic [NUM_REQ-1:0]      sel_oh;
  logic                    any_valid;
  logic                    window;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [HOLD_W-1:0]       sel_hold;

  gpio_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid_i   (req_valid_i),
    .ptr_i     (ptr),
    .sel_oh_o  (sel_oh),
    .sel_idx_o (sel_idx),
    .any_o     (any_valid)
  );

  // The window also opens on the last drive cycle so a waiting request follows without a bubble.
  assign window      = (state_q == IDLE) || (hold_q == '0);
  assign accept      = rst_ni && window && any_valid;
  assign req_ready_o = accept ? sel_oh : '0;

`ifdef GPIO_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  assign ptr = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    sel_data = '0;
    sel_hold = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_oh[i]) begin
        sel_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_hold = req_hold_i[i*HOLD_W +: HOLD_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pin_d   = pin_q;
    grant_d = grant_q;
    if (accept) begin
      state_d = DRIVE;
      hold_d  = sel_hold;
      pin_d   = sel_data;
      grant_d = NUM_REQ'(1) << sel_idx;
    end else if (state_q == DRIVE) begin
      if (hold_q != '0) begin
        hold_d = hold_q - HOLD_W'(1);
      end else begin
        // Pin value stays sticky after release; only ownership is dropped.
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hold_q  <= '0;
      pin_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pin_q   <= pin_d;
      grant_q <= grant_d;
    end
  end

  assign gpio_pin_o = pin_q;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q == DRIVE);

endmodule

// File: tb/tb_gpio_drive_arbiter.sv
// Randomized and directed bench for gpio_drive_arbiter against a cycle-level reference model.
module tb_gpio_drive_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int HW      = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*DW-1:0]  req_data;
  logic [NUM_REQ*HW-1:0]  req_hold;
  logic [NUM_REQ-1:0]     req_ready;
  logic [DW-1:0]          gpio_pin;
  logic [NUM_REQ-1:0]     grant;
  logic                   busy;

  gpio_drive_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .HOLD_W     (HW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_hold_i  (req_hold),
    .req_ready_o (req_ready),
    .gpio_pin_o  (gpio_pin),
    .grant_o     (grant),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Requester-side stimulus
  bit          tb_vld  [NUM_REQ];
  logic [DW-1:0] tb_data [NUM_REQ];
  logic [HW-1:0] tb_hold [NUM_REQ];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: who owns the pins, how many extra cycles remain, next search start
  bit          m_busy;
  int          m_rem;
  int          m_owner;
  int          m_ptr;
  int          last_acc;
  logic [DW-1:0] m_pin;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_rem = 0; m_owner = 0; m_ptr = 0; m_pin = '0; last_acc = -1;
  endtask

  function automatic int model_pick();
    for (int k = 0; k < NUM_REQ; k++) begin
      int i = (m_ptr + k) % NUM_REQ;
      if (tb_vld[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive_ports();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]          = tb_vld[i];
      req_data[i*DW +: DW]  = tb_data[i];
      req_hold[i*HW +: HW]  = tb_hold[i];
    end
  endtask

  // One clock cycle: called at posedge+1, checks ready mid-cycle and registered outputs after the edge.
  task automatic step();
    int w;
    logic [NUM_REQ-1:0] exp_rdy;
    drive_ports();
    #1;
    w = -1;
    exp_rdy = '0;
    if (!m_busy || m_rem == 0) begin
      w = model_pick();
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    chk("ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    last_acc = w;
    if (w >= 0) begin
      m_busy  = 1'b1;
      m_rem   = int'(tb_hold[w]);
      m_owner = w;
      m_pin   = tb_data[w];
`ifndef GPIO_ARB_FIXED_PRIO_EN
      m_ptr   = (w + 1) % NUM_REQ;
`endif
    end else if (m_busy) begin
      if (m_rem > 0) m_rem--;
      else           m_busy = 1'b0;
    end
    #1;
    chk("pin",   64'(gpio_pin), 64'(m_pin));
    chk("grant", 64'(grant),    m_busy ? (64'd1 << m_owner) : 64'd0);
    chk("busy",  64'(busy),     64'(m_busy));
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) tb_vld[i] = 1'b1;
    drive_ports();
    #1;
    chk("rst_pin",   64'(gpio_pin),  64'd0);
    chk("rst_grant", 64'(grant),     64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    model_reset();
    for (int i = 0; i < NUM_REQ; i++) tb_vld[i] = 1'b0;
    drive_ports();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  exp_order [5];
    int  cnt;
    bit  saw_g0;

`ifdef GPIO_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      tb_vld[i] = 1'b0; tb_data[i] = '0; tb_hold[i] = '0;
    end
    drive_ports();
    model_reset();
    #2;
    do_reset();

    // Single request: req 2, hold 3
    tb_vld[2] = 1'b1; tb_data[2] = 32'hA5A5_0001; tb_hold[2] = 8'd3;
    step();
    chk("single_grant", 64'(grant), 64'h4);
    chk("single_pin",   64'(gpio_pin), 64'hA5A5_0001);
    tb_vld[2] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("single_hold_pin",  64'(gpio_pin), 64'hA5A5_0001);
      chk("single_hold_busy", 64'(busy), (k < 4) ? 64'd1 : 64'd0);
    end

    // Back-to-back: req 1 hold 1, then req 3 waiting
    tb_vld[1] = 1'b1; tb_data[1] = 32'h1111_0001; tb_hold[1] = 8'd1;
    step();
    chk("b2b_first", 64'(gpio_pin), 64'h1111_0001);
    tb_vld[1] = 1'b0;
    tb_vld[3] = 1'b1; tb_data[3] = 32'h3333_0003; tb_hold[3] = 8'd0;
    step();
    chk("b2b_mid_pin",  64'(gpio_pin), 64'h1111_0001);
    chk("b2b_mid_busy", 64'(busy), 64'd1);
    step();
    chk("b2b_switch",      64'(gpio_pin), 64'h3333_0003);
    chk("b2b_switch_busy", 64'(busy), 64'd1);
    tb_vld[3] = 1'b0;
    step();

    // Withdrawal: req 0 raised and dropped while req 1 holds the pins
    tb_vld[1] = 1'b1; tb_data[1] = 32'h1111_00F0; tb_hold[1] = 8'd4;
    step();
    tb_vld[1] = 1'b0;
    tb_vld[0] = 1'b1; tb_data[0] = 32'hDEAD_0000; tb_hold[0] = 8'd2;
    saw_g0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      saw_g0 |= grant[0];
    end
    tb_vld[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      saw_g0 |= grant[0];
    end
    chk("wd_never_granted", 64'(saw_g0), 64'd0);
    chk("wd_idle",          64'(busy),   64'd0);
    chk("wd_sticky_pin",    64'(gpio_pin), 64'h1111_00F0);

    // Max hold: 256 drive cycles
    tb_vld[2] = 1'b1; tb_data[2] = 32'h0F0F_00FF; tb_hold[2] = 8'hFF;
    step();
    tb_vld[2] = 1'b0;
    cnt = busy ? 1 : 0;
    for (int g = 0; g < 300 && busy; g++) begin
      step();
      if (busy) cnt++;
    end
    chk("maxhold_len", 64'(cnt), 64'd256);

    // All four valid with hold 0 from reset
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      tb_vld[i] = 1'b1; tb_data[i] = 32'h1000_0000 + i; tb_hold[i] = 8'd0;
    end
    for (int j = 0; j < 5; j++) begin
      step();
      chk("order_grant", 64'(grant), 64'd1 << exp_order[j]);
      chk("order_busy",  64'(busy),  64'd1);
    end

    // Reset during the second cycle of a hold=10 drive
    for (int i = 0; i < NUM_REQ; i++) tb_vld[i] = 1'b0;
    tb_vld[3] = 1'b1; tb_data[3] = 32'h7777_000A; tb_hold[3] = 8'd10;
    step();
    tb_vld[3] = 1'b0;
    step();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) tb_vld[i] = 1'b1;
    step();
    chk("post_rst_first", 64'(grant), 64'h1);
    for (int i = 0; i < NUM_REQ; i++) tb_vld[i] = 1'b0;

    // Randomized traffic with withdrawals
    for (int c = 0; c < 1500; c++) begin
      step();
      if (last_acc >= 0) tb_vld[last_acc] = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!tb_vld[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            tb_vld[i]  = 1'b1;
            tb_data[i] = $urandom;
            tb_hold[i] = ($urandom_range(0, 7) == 0) ? HW'($urandom_range(0, 20))
                                                     : HW'($urandom_range(0, 3));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          tb_vld[i] = 1'b0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
